dp_record_serializer: RTL and testbench
=======================================

// Module: dp_record_serializer
// PURPOSE
//  Downstream stage of the data processing system. Drains result records
//  {MaxTime, MaxAmpl, ZeroOffset, CycleNumber} from the result FIFO and emits each one
//  as a framed byte stream on a valid/ready interface toward the host link (UART/USB bridge).
//  Frame: header byte, payload bytes MSB-first, then an 8-bit checksum byte.
// PARAMETERS
//  n      8      sample / amplitude width (MaxAmpl, ZeroOffset)
//  m      10     MaxTime width
//  k      12     CycleNumber width
//  HDR    8'hA5  frame header byte
//  RECW   m+n+n+k (derived, 38)      record width
//  NBYTES (RECW+7)/8 (derived, 5)    payload bytes; record zero-extended to NBYTES*8 bits
// PORTS
//  Clock       in   1       system clock, 100 MHz
//  Reset       in   1       asynchronous reset, active-high
//  Enable      in   1       1 = drain FIFO; 0 = finish current frame, then hold IDLE
//  FifoEmpty   in   1       result FIFO empty flag
//  ReadEna     out  1       FIFO read strobe, one cycle per record
//  ReadData    in   RECW    FIFO output {MaxTime,MaxAmpl,ZeroOffset,CycleNumber}
//  TxData      out  8       stream byte
//  TxValid     out  1       TxData valid
//  TxReady     in   1       sink accepts byte when TxValid && TxReady
//  FrameCount  out  16      frames fully sent since reset, wraps 16'hFFFF -> 0
//  Busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: ReadEna=0, TxValid=0, TxData=0, FrameCount=0, Busy=0, state=IDLE, payload reg=0.
//  FIFO read latency: ReadData valid the cycle after ReadEna (registered read).
//  FSM: IDLE -> POP -> LOAD -> HDR -> DATA -> CSUM -> IDLE.
//   IDLE: if Enable && !FifoEmpty -> POP. ReadEna never asserted while FifoEmpty=1.
//   POP : ReadEna=1 for exactly this cycle -> LOAD.
//   LOAD: capture zero-extended ReadData into payload shift reg; clear csum acc; byte cnt=0 -> HDR.
//   HDR : TxData=HDR, TxValid=1; on accept -> DATA.
//   DATA: TxData=payload[NBYTES*8-1 -:8]; on accept: acc+=byte (mod 256), shift left 8,
//         cnt++; after byte NBYTES-1 accepted -> CSUM.
//   CSUM: TxData = (0 - acc) mod 256 (payload bytes + csum == 0 mod 256; header excluded);
//         on accept: FrameCount++, -> IDLE.
//  Handshake: once TxValid=1, TxData stays stable and TxValid stays 1 until TxReady=1;
//   TxValid registered, no combinational path TxReady -> TxValid/TxData.
//   TxReady=1 constantly -> one byte per clock, frame = 2+(NBYTES+2) = 9 cycles from POP.
//  Enable deasserted mid-frame: frame completes normally; no new POP while Enable=0.
//  FIFO goes empty mid-frame: no effect on the current frame (record already captured).
//  Reset asserted mid-frame: immediate return to reset values; in-flight record discarded,
//   partial frame not resumed.
//  Back-to-back records: next POP no earlier than the cycle after CSUM accept (IDLE visited).
//  FrameCount increments only on CSUM accept; wraps silently.
// STRUCTURE
//  Shared include dpsystem_defs.vh: n/m/k defaults, HDR constant, RECW/NBYTES derivation,
//   state encodings (IDLE..CSUM) -- also used by the upstream data-processing block and the bench.
//  Single module; no sub-module needed (FSM + shift register + byte counter + 8-bit accumulator).
// TESTING
//  1 FIFO holds record MaxTime=10'h155, MaxAmpl=8'h7F, ZeroOffset=8'hF0, CycleNumber=12'h123,
//    TxReady=1 -> bytes A5 15 57 FF 01 23 71, one per cycle; FrameCount 0->1; single ReadEna pulse.
//  2 Same record, TxReady toggling 1,0,0,1 pseudo-randomly -> identical byte sequence, TxData
//    stable while TxValid && !TxReady, no byte dropped or duplicated.
//  3 FifoEmpty=1 for 100 cycles, Enable=1 -> ReadEna=0, TxValid=0, Busy=0 throughout.
//  4 Three records queued, TxReady=1 -> three 7-byte frames, one IDLE cycle between frames,
//    FrameCount=3, exactly 3 ReadEna pulses.
//  5 Enable dropped during DATA byte 2 -> frame completes through checksum, then Busy=0 and
//    no further ReadEna while FIFO non-empty; Enable=1 resumes with next record.
//  6 Reset pulsed during DATA byte 3 -> next cycle TxValid=0, Busy=0, FrameCount=0; after
//    release the next FIFO record is sent as a complete frame starting with A5.

Source files
------------

// File: rtl/dp_record_serializer_pkg.sv
// Shared widths, frame constants and state encoding for the record serializer.
// Record layout is {MaxTime, MaxAmpl, ZeroOffset, CycleNumber}.
package dp_record_serializer_pkg;

    localparam int n      = 8;
    localparam int m      = 10;
    localparam int k      = 12;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int RECW   = m + n + n + k;
    localparam int NBYTES = (RECW + 7) / 8;
    localparam int PAYW   = NBYTES * 8;
    localparam int CNTW   = $clog2(NBYTES);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        HEAD,
        DATA,
        CSUM
    } state_t;

    // Byte that brings the running payload sum to zero mod 256
    function automatic logic [7:0] csumOf(input logic [7:0] acc);
        return 8'(8'd0 - acc);
    endfunction

endpackage

// File: rtl/dp_record_serializer.sv
// Drains result records from the FIFO and emits each as a framed byte stream:
// header, payload MSB-first, two's-complement checksum of the payload bytes.
module dp_record_serializer
    import dp_record_serializer_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic            FifoEmpty,
    output logic            ReadEna,
    input  logic [RECW-1:0] ReadData,
    output logic [7:0]      TxData,
    output logic            TxValid,
    input  logic            TxReady,
    output logic [15:0]     FrameCount,
    output logic            Busy
);

    localparam logic [CNTW-1:0] LastByte = CNTW'(NBYTES - 1);

    state_t            state, stateNext;
    logic [PAYW-1:0]   payload, payloadNext;
    logic [7:0]        acc, accNext;
    logic [CNTW-1:0]   cnt, cntNext;
    logic [7:0]        txDataNext;
    logic              txValidNext;
    logic [15:0]       frameCountNext;
    logic              accept;

    assign accept  = TxValid && TxReady;
    assign ReadEna = (state == POP);
    assign Busy    = (state != IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next byte on the wire is registered together with the state move,
    // so TxValid/TxData never depend combinationally on TxReady.
    always_comb begin
        stateNext      = state;
        payloadNext    = payload;
        accNext        = acc;
        cntNext        = cnt;
        txDataNext     = TxData;
        txValidNext    = TxValid;
        frameCountNext = FrameCount;
        unique case (state)
            IDLE: begin
                if (Enable && !FifoEmpty) stateNext = POP;
            end
            POP: begin
                stateNext = LOAD;
            end
            LOAD: begin
                payloadNext = PAYW'(ReadData);
                accNext     = 8'd0;
                cntNext     = '0;
                txDataNext  = HDR;
                txValidNext = 1'b1;
                stateNext   = HEAD;
            end
            HEAD: begin
                if (accept) begin
                    txDataNext = payload[PAYW-1 -: 8];
                    stateNext  = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    accNext     = acc + TxData;
                    payloadNext = payload << 8;
                    cntNext     = cnt + 1'b1;
                    if (cnt == LastByte) begin
                        txDataNext = csumOf(accNext);
                        stateNext  = CSUM;
                    end else begin
                        txDataNext = payloadNext[PAYW-1 -: 8];
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    frameCountNext = FrameCount + 16'd1;
                    txValidNext    = 1'b0;
                    txDataNext     = 8'd0;
                    stateNext      = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            payload    <= '0;
            acc        <= 8'd0;
            cnt        <= '0;
            TxData     <= 8'd0;
            TxValid    <= 1'b0;
            FrameCount <= 16'd0;
        end else begin
            payload    <= payloadNext;
            acc        <= accNext;
            cnt        <= cntNext;
            TxData     <= txDataNext;
            TxValid    <= txValidNext;
            FrameCount <= frameCountNext;
        end
    end

endmodule

// File: tb/tb_dp_record_serializer.sv
// Randomized bench for dp_record_serializer with a FIFO model and a
// frame-level scoreboard built from record arithmetic.
module tb_dp_record_serializer;
    import dp_record_serializer_pkg::*;

    localparam int FrameLen = NBYTES + 2;

    logic            Clock;
    logic            Reset;
    logic            Enable;
    logic            fifoEmpty;
    logic            ReadEna;
    logic [RECW-1:0] readData;
    logic [7:0]      TxData;
    logic            TxValid;
    logic            TxReady;
    logic [15:0]     FrameCount;
    logic            Busy;

    logic [RECW-1:0] fifoMem [0:63];
    int              wrPtr = 0;
    int              rdPtr = 0;

    int              testsRun = 0;
    int              testsFailed = 0;
    int              readPulses = 0;
    int              modelFrames = 0;
    int              byteIdx = 0;
    logic [7:0]      expQ[$];
    logic [7:0]      gotQ[$];
    logic            prevStall = 1'b0;
    logic [7:0]      prevData = 8'd0;
    bit              randReady = 1'b0;
    logic [7:0]      golden [7];

    dp_record_serializer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .FifoEmpty  (fifoEmpty),
        .ReadEna    (ReadEna),
        .ReadData   (readData),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .TxReady    (TxReady),
        .FrameCount (FrameCount),
        .Busy       (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign fifoEmpty = (wrPtr == rdPtr);

    always @(posedge Clock) begin
        if (ReadEna) begin
            readData <= fifoMem[rdPtr % 64];
            rdPtr    <= rdPtr + 1;
        end
    end

    always @(negedge Clock) begin
        if (randReady) TxReady = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expectFrame(input logic [RECW-1:0] rec);
        longint unsigned v;
        int sum;
        int b;
        v   = longint'(rec);
        sum = 0;
        expQ.push_back(HDR);
        for (int i = 0; i < NBYTES; i++) begin
            b = int'((v >> (8 * (NBYTES - 1 - i))) % 256);
            sum += b;
            expQ.push_back(8'(b));
        end
        expQ.push_back(8'((256 - (sum % 256)) % 256));
    endtask

    task automatic push(input logic [RECW-1:0] rec);
        fifoMem[wrPtr % 64] = rec;
        wrPtr++;
    endtask

    function automatic logic [RECW-1:0] randRec();
        return RECW'({$urandom(), $urandom()});
    endfunction

    task automatic waitFrames(input int target, input int budget,
                              output int cyc);
        cyc = 0;
        while (int'(FrameCount) < target && cyc < budget) begin
            @(negedge Clock);
            #1;
            cyc++;
        end
        check("frameWait", 32'(int'(FrameCount) >= target), 32'd1);
    endtask

    task automatic checkGolden(input string tag, input int base);
        check({tag, "Len"}, 32'(gotQ.size() >= base + 7), 32'd1);
        if (gotQ.size() >= base + 7)
            for (int i = 0; i < 7; i++)
                check(tag, 32'(gotQ[base + i]), 32'(golden[i]));
    endtask

    // Scoreboard: samples mid-cycle what the next rising edge will see
    always begin
        @(negedge Clock);
        #2;
        if (Reset) begin
            expQ.delete();
            byteIdx     = 0;
            modelFrames = 0;
            prevStall   = 1'b0;
        end else begin
            if (prevStall) begin
                check("holdValid", 32'(TxValid), 32'd1);
                check("holdData", 32'(TxData), 32'(prevData));
            end
            if (ReadEna) begin
                readPulses++;
                check("readOnEmpty", 32'(fifoEmpty), 32'd0);
                expectFrame(fifoMem[rdPtr % 64]);
            end
            if (TxValid && TxReady) begin
                gotQ.push_back(TxData);
                if (expQ.size() == 0)
                    check("extraByte", 32'(TxData), 32'hFFFF_FFFF);
                else
                    check("txByte", 32'(TxData), 32'(expQ.pop_front()));
                byteIdx++;
                if (byteIdx == FrameLen) begin
                    byteIdx = 0;
                    modelFrames++;
                end
            end
            prevStall = TxValid && !TxReady;
            prevData  = TxData;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int p0;
        logic [RECW-1:0] rec1;

        golden = '{8'hA5, 8'h15, 8'h57, 8'hFF, 8'h01, 8'h23, 8'h71};
        rec1   = {10'h155, 8'h7F, 8'hF0, 12'h123};
        readData = '0;
        Reset    = 1'b1;
        Enable   = 1'b0;
        TxReady  = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        check("rstValid", 32'(TxValid), 32'd0);
        check("rstReadEna", 32'(ReadEna), 32'd0);
        check("rstBusy", 32'(Busy), 32'd0);
        check("rstCount", 32'(FrameCount), 32'd0);
        check("rstData", 32'(TxData), 32'd0);
        Reset   = 1'b0;
        Enable  = 1'b1;
        TxReady = 1'b1;

        // Known record, full-rate sink
        base = gotQ.size();
        push(rec1);
        waitFrames(1, 50, cyc);
        check("t1Cycles", 32'(cyc), 32'd10);
        checkGolden("t1Byte", base);
        check("t1Reads", 32'(readPulses), 32'd1);
        check("t1Count", 32'(FrameCount), 32'(modelFrames));

        // Same record with a stalling sink
        base = gotQ.size();
        randReady = 1'b1;
        push(rec1);
        waitFrames(2, 400, cyc);
        randReady = 1'b0;
        TxReady   = 1'b1;
        checkGolden("t2Byte", base);
        check("t2Reads", 32'(readPulses), 32'd2);

        // Empty FIFO keeps the block idle
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            #1;
            check("t3Idle", {29'd0, ReadEna, TxValid, Busy}, 32'd0);
        end

        // Back-to-back random records
        p0 = readPulses;
        for (int i = 0; i < 3; i++) push(randRec());
        waitFrames(5, 200, cyc);
        check("t4Cycles", 32'(cyc), 32'd30);
        check("t4Reads", 32'(readPulses - p0), 32'd3);
        check("t4Count", 32'(FrameCount), 32'(modelFrames));
        check("t4Drain", 32'(expQ.size()), 32'd0);

        // Enable dropped during payload byte 2
        p0 = readPulses;
        push(randRec());
        push(randRec());
        repeat (6) begin
            @(negedge Clock);
            #1;
        end
        check("t5BusyAtDrop", 32'(Busy), 32'd1);
        Enable = 1'b0;
        waitFrames(6, 50, cyc);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            #1;
            check("t5Hold", {30'd0, ReadEna, Busy}, 32'd0);
        end
        check("t5Pending", 32'(fifoEmpty), 32'd0);
        check("t5Reads", 32'(readPulses - p0), 32'd1);
        Enable = 1'b1;
        waitFrames(7, 50, cyc);
        check("t5Resume", 32'(readPulses - p0), 32'd2);
        check("t5Count", 32'(FrameCount), 32'(modelFrames));

        // Reset during payload byte 3, then next record goes out whole
        push(randRec());
        push(randRec());
        repeat (7) begin
            @(negedge Clock);
            #1;
        end
        check("t6BusyAtRst", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check("t6RstValid", 32'(TxValid), 32'd0);
        check("t6RstBusy", 32'(Busy), 32'd0);
        check("t6RstCount", 32'(FrameCount), 32'd0);
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        base  = gotQ.size();
        waitFrames(1, 50, cyc);
        check("t6Len", 32'(gotQ.size() - base), 32'(FrameLen));
        if (gotQ.size() > base)
            check("t6Header", 32'(gotQ[base]), 32'(HDR));
        check("t6Count", 32'(FrameCount), 32'(modelFrames));
        check("t6Drain", 32'(expQ.size()), 32'd0);
        check("t6Empty", 32'(fifoEmpty), 32'd1);

        repeat (5) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
